// File: rtl/pingpong_buf_if.sv
// Bus bundle between the ping-pong channel and its producer/consumer stages.
// The master side drives the stage requests; the slave side is the buffer.
interface pingpong_buf_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] prod_address0;
  logic                  prod_ce0;
  logic                  prod_we0;
  logic [DATA_WIDTH-1:0] prod_d0;
  logic                  prod_done;
  logic                  prod_start;
  logic                  prod_continue;
  logic [ADDR_WIDTH-1:0] cons_address0;
  logic [ADDR_WIDTH-1:0] cons_address1;
  logic                  cons_ce0;
  logic                  cons_ce1;
  logic [DATA_WIDTH-1:0] cons_q0;
  logic [DATA_WIDTH-1:0] cons_q1;
  logic                  cons_done;
  logic                  cons_start;
  logic                  cons_continue;
  logic [1:0]            full_cnt;
  logic                  err;

  modport master (
    output prod_address0, prod_ce0, prod_we0, prod_d0, prod_done,
           cons_address0, cons_address1, cons_ce0, cons_ce1, cons_done,
    input  prod_start, prod_continue, cons_q0, cons_q1, cons_start,
           cons_continue, full_cnt, err
  );

  modport slave (
    input  prod_address0, prod_ce0, prod_we0, prod_d0, prod_done,
           cons_address0, cons_address1, cons_ce0, cons_ce1, cons_done,
    output prod_start, prod_continue, cons_q0, cons_q1, cons_start,
           cons_continue, full_cnt, err
  );
endinterface

// File: rtl/pingpong_buf.sv
// Two-bank ping-pong channel: producer fills one bank while the consumer
// reads the other through two read ports; owns swap bookkeeping and handshakes.
//
// bank state | meaning
// EMPTY      | bank free, producer may write/commit into it
// FULL       | bank committed, consumer may read/release it
module pingpong_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic           ap_clk,
  input  logic           ap_rst,
  pingpong_buf_if.slave  bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_e;

  bank_state_e           state_q [2];
  bank_state_e           state_d [2];
  logic                  wsel_q, wsel_d;
  logic                  rsel_q, rsel_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] q0_q, q1_q;
  logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

  logic wr_fire, wr_drop, commit, rel_fire, bad_rel;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= '{EMPTY, EMPTY};
      wsel_q  <= 1'b0;
      rsel_q  <= 1'b0;
      err_q   <= 1'b0;
      q0_q    <= '0;
      q1_q    <= '0;
    end else begin
      state_q <= state_d;
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
      err_q   <= err_d;
      if (bus.cons_ce0) q0_q <= mem_q[rsel_q][bus.cons_address0];
      if (bus.cons_ce1) q1_q <= mem_q[rsel_q][bus.cons_address1];
    end
  end

  // Commit and release can never hit the same bank in one cycle: one needs
  // it EMPTY, the other FULL, so both updates are applied independently.
  always_comb begin
    state_d  = state_q;
    wsel_d   = wsel_q;
    rsel_d   = rsel_q;
    err_d    = err_q;
    wr_fire  = bus.prod_ce0 & bus.prod_we0 & (state_q[wsel_q] == EMPTY);
    wr_drop  = bus.prod_ce0 & bus.prod_we0 & (state_q[wsel_q] == FULL);
    commit   = bus.prod_done & (state_q[wsel_q] == EMPTY);
    rel_fire = bus.cons_done & (state_q[rsel_q] == FULL);
    bad_rel  = bus.cons_done & (state_q[rsel_q] == EMPTY);
    if (commit) begin
      state_d[wsel_q] = FULL;
      wsel_d          = ~wsel_q;
    end
    if (rel_fire) begin
      state_d[rsel_q] = EMPTY;
      rsel_d          = ~rsel_q;
    end
    if (wr_drop || bad_rel) err_d = 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (wr_fire) mem_q[wsel_q][bus.prod_address0] <= bus.prod_d0;
  end

  assign bus.prod_start    = (state_q[wsel_q] == EMPTY);
  assign bus.prod_continue = commit & ~ap_rst;
  assign bus.cons_start    = (state_q[rsel_q] == FULL);
  assign bus.cons_continue = ~ap_rst;
  assign bus.full_cnt      = {1'b0, state_q[0] == FULL} + {1'b0, state_q[1] == FULL};
  assign bus.err           = err_q;
  assign bus.cons_q0       = q0_q;
  assign bus.cons_q1       = q1_q;

endmodule

// File: tb/tb_pingpong_buf.sv
// Bench for pingpong_buf: directed vector table, hand-written reset and
// protocol corner cases, then random traffic against a bank-count model.
module tb_pingpong_buf;
  localparam int DW = 32;
  localparam int AW = 4;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  pingpong_buf_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  pingpong_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] wa;
    logic          we;
    logic [DW-1:0] wd;
    logic          pdone;
    logic [AW-1:0] a0;
    logic          ce0;
    logic [AW-1:0] a1;
    logic          ce1;
    logic          cdone;
    logic          e_pstart;
    logic          e_pcont;
    logic          e_cstart;
    logic [1:0]    e_fcnt;
    logic          e_err;
    logic          chk_q;
    logic [DW-1:0] e_q0;
    logic [DW-1:0] e_q1;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    bus.prod_address0 = '0; bus.prod_ce0 = 0; bus.prod_we0 = 0; bus.prod_d0 = '0;
    bus.prod_done = 0; bus.cons_address0 = '0; bus.cons_address1 = '0;
    bus.cons_ce0 = 0; bus.cons_ce1 = 0; bus.cons_done = 0;
  endtask

  task automatic do_reset();
    clear_in();
    ap_rst = 1'b1;
    @(posedge ap_clk);
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
  endtask

  function automatic vec_t v(input logic ps, input logic pc, input logic cs,
                             input logic [1:0] fc, input logic er);
    vec_t t = '{default: 0};
    t.e_pstart = ps; t.e_pcont = pc; t.e_cstart = cs; t.e_fcnt = fc; t.e_err = er;
    return t;
  endfunction

  task automatic apply_vec(input int i, input vec_t t);
    bus.prod_address0 = t.wa; bus.prod_ce0 = t.we; bus.prod_we0 = t.we;
    bus.prod_d0 = t.wd; bus.prod_done = t.pdone;
    bus.cons_address0 = t.a0; bus.cons_ce0 = t.ce0;
    bus.cons_address1 = t.a1; bus.cons_ce1 = t.ce1; bus.cons_done = t.cdone;
    @(negedge ap_clk);
    chk($sformatf("vec%0d prod_start", i), bus.prod_start, t.e_pstart);
    chk($sformatf("vec%0d prod_continue", i), bus.prod_continue, t.e_pcont);
    chk($sformatf("vec%0d cons_start", i), bus.cons_start, t.e_cstart);
    chk($sformatf("vec%0d full_cnt", i), bus.full_cnt, t.e_fcnt);
    chk($sformatf("vec%0d err", i), bus.err, t.e_err);
    if (t.chk_q) begin
      chk($sformatf("vec%0d cons_q0", i), bus.cons_q0, t.e_q0);
      chk($sformatf("vec%0d cons_q1", i), bus.cons_q1, t.e_q1);
    end
    @(posedge ap_clk);
    #1;
  endtask

  // Random-phase model: banks fill and drain strictly in order, so the whole
  // state is the number of full banks plus which bank the consumer owns.
  int            m_n, m_r;
  logic [DW-1:0] m_mem [2][16];
  bit            m_vld [2][16];
  logic [DW-1:0] m_q0, m_q1;
  bit            m_q0v, m_q1v, m_err;

  initial begin
    vec_t t;
    logic [DW-1:0] dead;
    dead = 32'hDEAD;

    // Directed table: fill bank0, dual read, fill bank1, back-pressure,
    // dropped write, release/commit overlap, readbacks.
    for (int a = 0; a < 16; a++) begin
      t = v(1, 0, 0, 0, 0); t.we = 1; t.wa = AW'(a); t.wd = DW'(a + 100); vecs.push_back(t);
    end
    t = v(1, 1, 0, 0, 0); t.pdone = 1; vecs.push_back(t);
    t = v(1, 0, 1, 1, 0); t.ce0 = 1; t.a0 = 3; t.ce1 = 1; t.a1 = 15; vecs.push_back(t);
    t = v(1, 0, 1, 1, 0); t.chk_q = 1; t.e_q0 = 103; t.e_q1 = 115; vecs.push_back(t);
    for (int a = 0; a < 16; a++) begin
      t = v(1, 0, 1, 1, 0); t.we = 1; t.wa = AW'(a); t.wd = DW'(a + 200); vecs.push_back(t);
    end
    t = v(1, 1, 1, 1, 0); t.pdone = 1; vecs.push_back(t);
    t = v(0, 0, 1, 2, 0); t.pdone = 1; vecs.push_back(t);
    t = v(0, 0, 1, 2, 0); t.pdone = 1; t.we = 1; t.wa = 5; t.wd = dead; vecs.push_back(t);
    t = v(0, 0, 1, 2, 1); t.pdone = 1; t.cdone = 1; vecs.push_back(t);
    t = v(1, 1, 1, 1, 1); t.pdone = 1; vecs.push_back(t);
    t = v(0, 0, 1, 2, 1); t.ce0 = 1; t.a0 = 5; t.ce1 = 1; t.a1 = 5; vecs.push_back(t);
    t = v(0, 0, 1, 2, 1); t.cdone = 1; t.chk_q = 1; t.e_q0 = 205; t.e_q1 = 205; vecs.push_back(t);
    t = v(1, 0, 1, 1, 1); t.ce0 = 1; t.a0 = 5; t.ce1 = 1; t.a1 = 0; vecs.push_back(t);
    t = v(1, 0, 1, 1, 1); t.cdone = 1; t.chk_q = 1; t.e_q0 = 105; t.e_q1 = 100; vecs.push_back(t);
    t = v(1, 0, 0, 0, 1); vecs.push_back(t);

    // Reset values while ap_rst is held
    clear_in();
    #2;
    chk("rst prod_start", bus.prod_start, 1);
    chk("rst prod_continue", bus.prod_continue, 0);
    chk("rst cons_start", bus.cons_start, 0);
    chk("rst cons_continue", bus.cons_continue, 0);
    chk("rst full_cnt", bus.full_cnt, 0);
    chk("rst err", bus.err, 0);
    chk("rst cons_q0", bus.cons_q0, 0);
    chk("rst cons_q1", bus.cons_q1, 0);
    do_reset();

    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // Release with no full bank is ignored but flagged
    do_reset();
    bus.cons_done = 1;
    @(negedge ap_clk);
    chk("badrel err before", bus.err, 0);
    @(posedge ap_clk); #1 bus.cons_done = 0;
    @(negedge ap_clk);
    chk("badrel err", bus.err, 1);
    chk("badrel full_cnt", bus.full_cnt, 0);
    chk("badrel cons_start", bus.cons_start, 0);
    chk("badrel prod_start", bus.prod_start, 1);
    chk("badrel cons_continue", bus.cons_continue, 1);

    // Asynchronous reset in the middle of a fill
    @(posedge ap_clk); #1;
    for (int a = 0; a < 16; a++) begin
      bus.prod_ce0 = 1; bus.prod_we0 = 1; bus.prod_address0 = AW'(a); bus.prod_d0 = DW'(a + 7);
      @(posedge ap_clk); #1;
    end
    bus.prod_ce0 = 0; bus.prod_we0 = 0; bus.prod_done = 1;
    @(posedge ap_clk); #1;
    bus.prod_done = 0; bus.cons_ce0 = 1; bus.cons_address0 = 2;
    bus.cons_ce1 = 1; bus.cons_address1 = 3;
    @(posedge ap_clk); #1;
    bus.cons_ce0 = 0; bus.cons_ce1 = 0;
    chk("prefill cons_q0", bus.cons_q0, 9);
    chk("prefill full_cnt", bus.full_cnt, 1);
    for (int a = 0; a < 7; a++) begin
      bus.prod_ce0 = 1; bus.prod_we0 = 1; bus.prod_address0 = AW'(a); bus.prod_d0 = DW'(a);
      @(posedge ap_clk); #1;
    end
    bus.prod_done = 1;
    #2 ap_rst = 1'b1;
    #1;
    chk("midrst prod_start", bus.prod_start, 1);
    chk("midrst prod_continue", bus.prod_continue, 0);
    chk("midrst cons_start", bus.cons_start, 0);
    chk("midrst cons_continue", bus.cons_continue, 0);
    chk("midrst full_cnt", bus.full_cnt, 0);
    chk("midrst err", bus.err, 0);
    chk("midrst cons_q0", bus.cons_q0, 0);
    chk("midrst cons_q1", bus.cons_q1, 0);
    clear_in();
    @(posedge ap_clk); #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("postrst prod_start", bus.prod_start, 1);
    chk("postrst cons_start", bus.cons_start, 0);
    chk("postrst full_cnt", bus.full_cnt, 0);
    chk("postrst cons_continue", bus.cons_continue, 1);
    @(posedge ap_clk); #1;

    // Random traffic against the model
    do_reset();
    m_n = 0; m_r = 0; m_q0 = '0; m_q1 = '0; m_q0v = 1; m_q1v = 1; m_err = 0;
    foreach (m_vld[b, a]) m_vld[b][a] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int wb;
      bit commit, rel;
      bus.prod_ce0 = ($urandom_range(0, 2) != 0);
      bus.prod_we0 = ($urandom_range(0, 3) != 0);
      bus.prod_address0 = AW'($urandom_range(0, 15));
      bus.prod_d0 = $urandom;
      bus.prod_done = ($urandom_range(0, 5) == 0);
      bus.cons_ce0 = $urandom_range(0, 1);
      bus.cons_ce1 = $urandom_range(0, 1);
      bus.cons_address0 = AW'($urandom_range(0, 15));
      bus.cons_address1 = AW'($urandom_range(0, 15));
      bus.cons_done = ($urandom_range(0, 6) == 0);
      @(negedge ap_clk);
      chk($sformatf("rnd%0d prod_start", cyc), bus.prod_start, (m_n < 2));
      chk($sformatf("rnd%0d prod_continue", cyc), bus.prod_continue, (bus.prod_done && m_n < 2));
      chk($sformatf("rnd%0d cons_start", cyc), bus.cons_start, (m_n > 0));
      chk($sformatf("rnd%0d full_cnt", cyc), bus.full_cnt, m_n);
      chk($sformatf("rnd%0d err", cyc), bus.err, m_err);
      if (m_q0v) chk($sformatf("rnd%0d cons_q0", cyc), bus.cons_q0, m_q0);
      if (m_q1v) chk($sformatf("rnd%0d cons_q1", cyc), bus.cons_q1, m_q1);
      wb = (m_r + m_n) % 2;
      if (bus.cons_ce0) begin
        m_q0 = m_mem[m_r][bus.cons_address0]; m_q0v = m_vld[m_r][bus.cons_address0];
      end
      if (bus.cons_ce1) begin
        m_q1 = m_mem[m_r][bus.cons_address1]; m_q1v = m_vld[m_r][bus.cons_address1];
      end
      if (bus.prod_ce0 && bus.prod_we0) begin
        if (m_n < 2) begin
          m_mem[wb][bus.prod_address0] = bus.prod_d0;
          m_vld[wb][bus.prod_address0] = 1;
        end else m_err = 1;
      end
      commit = bus.prod_done && (m_n < 2);
      rel    = bus.cons_done && (m_n > 0);
      if (bus.cons_done && m_n == 0) m_err = 1;
      m_n = m_n + int'(commit) - int'(rel);
      if (rel) m_r = 1 - m_r;
      @(posedge ap_clk); #1;
    end

    clear_in();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pingpong_buf.md
# pingpong_buf

Two-bank ping-pong channel placed between two merge-sort dataflow stages. The upstream stage writes a full 16-word pass into one bank through a single write port. Meanwhile the downstream stage reads the other bank through two independent read ports. The block owns the bank-swap bookkeeping and drives the ap_ctrl_chain start/continue handshakes of both stages.

## Interface
Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 4, address width per bank.
- DEPTH, 16, words per bank (2**ADDR_WIDTH).

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- prod_address0  in  ADDR_WIDTH  producer write address.
- prod_ce0  in  1  producer port enable.
- prod_we0  in  1  producer write enable.
- prod_d0  in  DATA_WIDTH  producer write data.
- prod_done  in  1  producer ap_done (level, held until continue).
- prod_start  out  1  producer ap_start: write bank is free.
- prod_continue  out  1  producer ap_continue: commit accepted this cycle.
- cons_address0 / cons_address1  in  ADDR_WIDTH  consumer read addresses.
- cons_ce0 / cons_ce1  in  1  consumer read enables.
- cons_q0 / cons_q1  out  DATA_WIDTH  read data, registered.
- cons_done  in  1  consumer ap_done.
- cons_start  out  1  consumer ap_start: a filled bank is readable.
- cons_continue  out  1  consumer ap_continue.
- full_cnt  out  2  number of banks in FULL state (0..2).
- err  out  1  sticky protocol-violation flag.

## Operation
- Each bank has a 1-bit state, EMPTY or FULL.
- Two 1-bit pointers: wsel selects the producer bank, rsel selects the consumer bank.
- prod_start = (state[wsel]==EMPTY), combinational.
- Write: if prod_ce0 & prod_we0 & state[wsel]==EMPTY, then mem[wsel][prod_address0] <= prod_d0.
  - A write while state[wsel]==FULL is dropped and sets err.
- Commit:
  - prod_continue = prod_done & state[wsel]==EMPTY, combinational.
  - On a commit cycle: state[wsel] <= FULL and wsel toggles.
  - While prod_done is high and state[wsel]==FULL, prod_continue stays 0 (back-pressure). The producer's done stays asserted.
- cons_start = (state[rsel]==FULL), combinational.
- Reads:
  - If cons_ceN, then cons_qN <= mem[rsel][cons_addressN].
  - Port 0 and port 1 are independent, and both may hit the same address.
  - If cons_ceN is 0, cons_qN holds its value.
- Release:
  - cons_continue = 1 whenever not in reset, so consumer ap_done is a 1-cycle pulse.
  - cons_done & state[rsel]==FULL: state[rsel] <= EMPTY and rsel toggles.
  - cons_done while state[rsel]==EMPTY is ignored and sets err.
- A simultaneous commit and release always target different banks; both take effect in the same cycle.
  - If both banks were FULL, the release frees rsel. The commit is not accepted that cycle, because state[wsel] is sampled before the update.
- full_cnt = state[0] + state[1], registered view of the state bits.
- Memory array is not reset. Its contents are undefined after reset.

## Timing
- Reset values:
  - states EMPTY; wsel = rsel = 0.
  - cons_q0 = cons_q1 = 0; full_cnt = 0; err = 0.
  - prod_start = 1; prod_continue = 0; cons_start = 0; cons_continue = 0.
- Reset takes effect immediately and asynchronously, even mid-pass. The partial pass is discarded. The first cycle after deassert behaves like a fresh start.
- Write-to-commit: a write in cycle t, then prod_done in cycle t+1, gives cons_start = 1 in cycle t+2.
- Read latency: 1 cycle from cons_ce to cons_q.
- Release: cons_done in cycle t gives prod_start = 1 in cycle t+1 if the producer was blocked on that bank.
- err stays set until ap_rst.

## Test plan
- Fill bank0 with mem[a]=a+100 for a=0..15, then pulse prod_done -> prod_continue=1 that cycle; cons_start=1 and prod_start=1 the next cycle; full_cnt=1.
- Dual read: cons_address0=3 and cons_address1=15 with both ce -> next cycle cons_q0=103, cons_q1=115.
- Fill both banks without consumer done -> full_cnt=2, prod_start=0. Hold prod_done high -> prod_continue stays 0. Then pulse cons_done -> prod_continue=1 on the next cycle.
- Write while the write bank is FULL (addr 5, data 0xDEAD) -> data is not stored and err=1. A later readback of addr 5 still returns the old value.
- cons_done with full_cnt=0 -> no state change, err=1.
- Assert ap_rst mid-fill (after 7 writes) -> all outputs return to reset values immediately. After deassert, prod_start=1 and cons_start=0.
